// File: rtl/i2c_target_core.sv
// I2C target engine: synchronises the pads, detects START/STOP, matches a
// 7-bit device address, and moves bytes to and from a local byte interface.
// SCL is never driven, and the target never stretches the clock.
module i2c_target_core #(
    parameter logic [6:0] DEV_ADDR    = 7'h42,
    parameter int          SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       scl_pad_i,
    output logic       scl_pad_o,
    output logic       scl_padoen_o,
    input  logic       sda_pad_i,
    output logic       sda_pad_o,
    output logic       sda_padoen_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic [7:0] tx_data_i,
    output logic       tx_rd_o,
    output logic       start_o,
    output logic       stop_o,
    output logic       nack_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK
    } state_e;

    // Pad synchronisers and the delay stage used for edge detection.
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_dly_q, sda_dly_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_evt, stop_evt;

    // Engine state.
    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] sr_q, sr_d;
    logic       rw_q, rw_d;
    logic       ack_phase_q, ack_phase_d;
    logic       busy_q, busy_d;
    logic       sda_oen_q, sda_oen_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_rd_q, tx_rd_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;
    logic       nack_q, nack_d;

    // Shift each pad into its synchroniser chain.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_pad_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_pad_i};
    end

    // Synchroniser and delay flops; an idle bus reads as all ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_dly_q  <= 1'b1;
            sda_dly_q  <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge values, independent of statement order.
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_dly_q  <= scl_s;
            sda_dly_q  <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  =  scl_s & ~scl_dly_q;
    assign scl_fall  = ~scl_s &  scl_dly_q;
    assign start_evt =  scl_s &  scl_dly_q & ~sda_s &  sda_dly_q;
    assign stop_evt  =  scl_s &  scl_dly_q &  sda_s & ~sda_dly_q;

    // Next-state logic: bus events first, then the bit-level protocol.
    always_comb begin
        // NOTE: every variable gets a default here so no path infers a latch.
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sr_d        = sr_q;
        rw_d        = rw_q;
        ack_phase_d = ack_phase_q;
        busy_d      = busy_q;
        sda_oen_d   = sda_oen_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_rd_d     = 1'b0;
        start_d     = 1'b0;
        stop_d      = 1'b0;
        nack_d      = 1'b0;

        if (start_evt) begin
            start_d     = 1'b1;
            sda_oen_d   = 1'b1;
            busy_d      = 1'b0;
            bit_cnt_d   = 3'd0;
            ack_phase_d = 1'b0;
            state_d     = S_ADDR;
        end else if (stop_evt) begin
            stop_d      = busy_q;
            sda_oen_d   = 1'b1;
            busy_d      = 1'b0;
            bit_cnt_d   = 3'd0;
            ack_phase_d = 1'b0;
            state_d     = S_IDLE;
        end else begin
            // The read byte is taken in the cycle tx_rd_o is high, and its MSB
            // goes onto the bus straight away while SCL is still low.
            if (tx_rd_q && state_q == S_RD_DATA) begin
                sr_d      = tx_data_i;
                sda_oen_d = tx_data_i[7];
            end

            case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        sr_d      = {sr_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = 3'd0;
                            rw_d      = sda_s;
                            if (sr_q[6:0] == DEV_ADDR) begin
                                busy_d      = 1'b1;
                                ack_phase_d = 1'b0;
                                state_d     = S_ADDR_ACK;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    end
                end

                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_oen_d   = 1'b0;
                            ack_phase_d = 1'b1;
                        end else begin
                            ack_phase_d = 1'b0;
                            bit_cnt_d   = 3'd0;
                            if (rw_q) begin
                                tx_rd_d = 1'b1;
                                state_d = S_RD_DATA;
                            end else begin
                                sda_oen_d = 1'b1;
                                state_d   = S_WR_DATA;
                            end
                        end
                    end
                end

                S_WR_DATA: begin
                    if (scl_rise) begin
                        sr_d      = {sr_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d   = {sr_q[6:0], sda_s};
                            rx_valid_d  = 1'b1;
                            bit_cnt_d   = 3'd0;
                            ack_phase_d = 1'b0;
                            state_d     = S_WR_ACK;
                        end
                    end
                end

                S_WR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_oen_d   = 1'b0;
                            ack_phase_d = 1'b1;
                        end else begin
                            sda_oen_d   = 1'b1;
                            ack_phase_d = 1'b0;
                            state_d     = S_WR_DATA;
                        end
                    end
                end

                S_RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_oen_d   = 1'b1;
                            bit_cnt_d   = 3'd0;
                            ack_phase_d = 1'b0;
                            state_d     = S_RD_ACK;
                        end else begin
                            sda_oen_d = sr_q[6];
                            sr_d      = {sr_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end

                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            nack_d    = 1'b1;
                            sda_oen_d = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            ack_phase_d = 1'b1;
                        end
                    end else if (scl_fall && ack_phase_q) begin
                        tx_rd_d     = 1'b1;
                        ack_phase_d = 1'b0;
                        bit_cnt_d   = 3'd0;
                        state_d     = S_RD_DATA;
                    end
                end

                default: begin
                    // Idle or unaddressed: only START/STOP matter.
                end
            endcase
        end
    end

    // Engine registers; reset releases SDA without waiting for a clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            sr_q        <= 8'h00;
            rw_q        <= 1'b0;
            ack_phase_q <= 1'b0;
            busy_q      <= 1'b0;
            sda_oen_q   <= 1'b1;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_rd_q     <= 1'b0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            nack_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            rw_q        <= rw_d;
            ack_phase_q <= ack_phase_d;
            busy_q      <= busy_d;
            sda_oen_q   <= sda_oen_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_rd_q     <= tx_rd_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            nack_q      <= nack_d;
        end
    end

    assign scl_pad_o    = 1'b0;
    assign scl_padoen_o = 1'b1;
    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = sda_oen_q;
    assign rx_data_o    = rx_data_q;
    assign rx_valid_o   = rx_valid_q;
    assign tx_rd_o      = tx_rd_q;
    assign start_o      = start_q;
    assign stop_o       = stop_q;
    assign nack_o       = nack_q;
    assign busy_o       = busy_q;

endmodule
